// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial frame transmitter.
//   tx_state_e  : transmitter FSM states
//   *_LEVEL     : fixed line levels for start, stop and idle
package serial_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic START_LEVEL = 1'b1;
    localparam logic STOP_LEVEL  = 1'b0;
    localparam logic IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word handshake into the serial frame transmitter.
//   in_data  : word to transmit, sampled on acceptance
//   in_valid : in_data is valid
//   in_ready : transmitter can accept a word
// master = word producer, slave = transmitter.
interface serial_frame_tx_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/bit_tick_gen.sv
// Bit period timer: counts 0..BIT_CYCLES-1 and flags the last cycle of each period.
//   clk, reset_n : clock, asynchronous active-low reset
//   restart      : realign the period so the next cycle is count 0
//   tick         : high on the last cycle of each bit period
module bit_tick_gen #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = $clog2(BIT_CYCLES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LastCnt);
        cnt_d = (restart || tick) ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, optional even
// parity bit, stop bit, each held BIT_CYCLES clocks.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : word handshake (slave side)
//   out          : serial line
//   busy         : frame in progress
//   done         : one-cycle pulse in the IDLE cycle after a frame
// All outputs come straight from flops, which are loaded from next-state values so
// they line up with the state register.
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned PARITY_EN  = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    serial_frame_tx_if.slave   bus,
    output logic               out,
    output logic               busy,
    output logic               done
);

    localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

    tx_state_e           state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic                parity_q, parity_d;
    logic                out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                in_ready_q, in_ready_d;
    logic                accept;
    logic                tick;

    bit_tick_gen #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (accept),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        accept    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    shift_d  = bus.in_data;
                    parity_d = ^bus.in_data;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            StParity: begin
                if (tick) state_d = StStop;
            end
            StStop: begin
                if (tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        out_d = IDLE_LEVEL;
        unique case (state_d)
            StIdle:   out_d = IDLE_LEVEL;
            StStart:  out_d = START_LEVEL;
            StData:   out_d = shift_d[0];
            StParity: out_d = parity_d;
            StStop:   out_d = STOP_LEVEL;
            default:  out_d = IDLE_LEVEL;
        endcase

        busy_d     = (state_d != StIdle);
        in_ready_d = (state_d == StIdle);
        done_d     = (state_q == StStop) && (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            parity_q   <= 1'b0;
            out_q      <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            parity_q   <= parity_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out          = out_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign bus.in_ready = in_ready_q;

endmodule
